// File: rtl/bpu_resolve_queue.sv
// Branch resolve queue: holds predictions until execute resolves them; upd/redirect are registered, 1 cycle after resolve.
// pred_ready drops when full or during the post-mispredict FLUSH cycle. BPU_STATS_EN adds saturating stat counters.
module bpu_resolve_queue #(
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pred_valid,
  output logic              pred_ready,
  input  logic [ADDR_W-1:0] pred_pc,
  input  logic              pred_taken,
  input  logic              pred_hit,
  input  logic [ADDR_W-1:0] pred_target,
  input  logic              res_valid,
  input  logic              res_taken,
  input  logic [ADDR_W-1:0] res_target,
  output logic              upd_valid,
  output logic              upd_taken,
  output logic              upd_btb_wr,
  output logic [23:0]       upd_tag,
  output logic [ADDR_W-1:0] upd_target,
  output logic              redirect_valid,
  output logic [ADDR_W-1:0] redirect_pc,
  output logic [PTR_W:0]    count
`ifdef BPU_STATS_EN
  ,
  output logic [31:0]       stat_resolved,
  output logic [31:0]       stat_mispred,
  output logic [15:0]       stat_full_cyc
`endif
);

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic              taken;
    logic              hit;
    logic [ADDR_W-1:0] target;
  } entry_t;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  entry_t            mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]    count_q, count_d;
  state_t            state_q;

  entry_t            head;
  logic [ADDR_W-1:0] head_pc4;
  logic              push, pop, btb_wr, mispred;

  assign count      = count_q;
  assign pred_ready = (count_q != FULL_CNT) && (state_q == RUN);
  assign push       = pred_valid && pred_ready;
  assign pop        = res_valid && (count_q != '0) && (state_q == RUN);

  assign head     = mem_q[rd_ptr_q];
  assign head_pc4 = head.pc + ADDR_W'(4);
  assign btb_wr   = res_taken && (!head.hit || head.target != res_target);
  assign mispred  = (res_taken != head.taken) || btb_wr ||
                    (!res_taken && head.target != head_pc4);

  always_comb begin
    count_d = count_q;
    if (push && !pop)
      count_d = count_q + CNT_ONE;
    else if (pop && !push)
      count_d = count_q - CNT_ONE;
  end

  // Storage needs no reset; a push discarded by a mispredict writes a slot that is never read.
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= '{pc: pred_pc, taken: pred_taken, hit: pred_hit, target: pred_target};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      upd_valid      <= 1'b0;
      upd_taken      <= 1'b0;
      upd_btb_wr     <= 1'b0;
      upd_tag        <= '0;
      upd_target     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
    end else begin
      upd_valid      <= pop;
      redirect_valid <= pop && mispred;
      if (pop) begin
        upd_taken  <= res_taken;
        upd_btb_wr <= btb_wr;
        upd_tag    <= head.pc[31:8];
        upd_target <= res_target;
      end
      if (pop && mispred) begin
        redirect_pc <= res_taken ? res_target : head_pc4;
        rd_ptr_q    <= wr_ptr_q;
        count_q     <= '0;
        state_q     <= FLUSH;
      end else begin
        state_q <= RUN;
        count_q <= count_d;
        if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

`ifdef BPU_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_resolved <= '0;
      stat_mispred  <= '0;
      stat_full_cyc <= '0;
    end else begin
      if (pop && stat_resolved != '1)
        stat_resolved <= stat_resolved + 32'd1;
      if (pop && mispred && stat_mispred != '1)
        stat_mispred <= stat_mispred + 32'd1;
      if (count_q == FULL_CNT && pred_valid && stat_full_cyc != '1)
        stat_full_cyc <= stat_full_cyc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bpu_resolve_queue.sv
// Randomized + directed bench for bpu_resolve_queue against a queue-based reference model.
module tb_bpu_resolve_queue;
  localparam int DEPTH = 8;

  logic        clk, rst;
  logic        pred_valid, pred_ready, pred_taken, pred_hit;
  logic [31:0] pred_pc, pred_target;
  logic        res_valid, res_taken;
  logic [31:0] res_target;
  logic        upd_valid, upd_taken, upd_btb_wr;
  logic [23:0] upd_tag;
  logic [31:0] upd_target;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [3:0]  count;
`ifdef BPU_STATS_EN
  logic [31:0] stat_resolved, stat_mispred;
  logic [15:0] stat_full_cyc;
`endif

  bpu_resolve_queue #(.DEPTH(DEPTH), .PTR_W(3), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_ready(pred_ready), .pred_pc(pred_pc),
    .pred_taken(pred_taken), .pred_hit(pred_hit), .pred_target(pred_target),
    .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
    .upd_valid(upd_valid), .upd_taken(upd_taken), .upd_btb_wr(upd_btb_wr),
    .upd_tag(upd_tag), .upd_target(upd_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .count(count)
`ifdef BPU_STATS_EN
    , .stat_resolved(stat_resolved), .stat_mispred(stat_mispred), .stat_full_cyc(stat_full_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    bit          taken;
    bit          hit;
    logic [31:0] tgt;
  } ent_t;

  ent_t q[$];
  bit   flush_m;
  int   checks, failures;
  int   m_resolved, m_mispred, m_full;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic bit is_mis(ent_t e, bit rt, logic [31:0] rtgt);
    logic [31:0] seq;
    seq = e.pc + 32'd4;
    return (rt != e.taken) || (rt && (!e.hit || e.tgt != rtgt)) || (!rt && e.tgt != seq);
  endfunction

  // One clock cycle: drive inputs, check ready, advance model, check registered outputs.
  task automatic step(input bit pv, input logic [31:0] pc, input bit pt, input bit ph,
                      input logic [31:0] ptgt, input bit rv, input bit rt, input logic [31:0] rtgt);
    bit          rdy_e, push, pop, mis, e_uv, e_rv;
    bit          e_tk, e_bw;
    logic [31:0] e_tgt, e_rpc, e_tag;
    ent_t        e, n;
    pred_valid = pv; pred_pc = pc; pred_taken = pt; pred_hit = ph; pred_target = ptgt;
    res_valid = rv; res_taken = rt; res_target = rtgt;
    #1;
    rdy_e = (q.size() != DEPTH) && !flush_m;
    chk("pred_ready", pred_ready, rdy_e);
    push = pv && rdy_e;
    pop  = rv && q.size() != 0 && !flush_m;
    if (q.size() == DEPTH && pv && m_full != 16'hFFFF) m_full++;
    e_uv = pop; e_rv = 0; mis = 0;
    e_tk = 0; e_bw = 0; e_tgt = 0; e_rpc = 0; e_tag = 0;
    if (pop) begin
      e = q[0];
      mis = is_mis(e, rt, rtgt);
      e_tk = rt;
      e_bw = rt && (!e.hit || e.tgt != rtgt);
      e_tag = e.pc >> 8;
      e_tgt = rtgt;
      m_resolved++;
      if (mis) begin
        m_mispred++;
        e_rv = 1;
        e_rpc = rt ? rtgt : e.pc + 32'd4;
      end
    end
    flush_m = pop && mis;
    if (pop && mis) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        n.pc = pc; n.taken = pt; n.hit = ph; n.tgt = ptgt;
        q.push_back(n);
      end
    end
    @(posedge clk); #1;
    chk("upd_valid", upd_valid, e_uv);
    chk("redirect_valid", redirect_valid, e_rv);
    chk("count", count, q.size());
    if (e_uv) begin
      chk("upd_taken", upd_taken, e_tk);
      chk("upd_btb_wr", upd_btb_wr, e_bw);
      chk("upd_tag", upd_tag, e_tag);
      chk("upd_target", upd_target, e_tgt);
    end
    if (e_rv) chk("redirect_pc", redirect_pc, e_rpc);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic push1(input logic [31:0] pc, input bit pt, input bit ph, input logic [31:0] tgt);
    step(1, pc, pt, ph, tgt, 0, 0, 0);
  endtask

  task automatic resolve(input bit rt, input logic [31:0] rtgt);
    step(0, 0, 0, 0, 0, 1, rt, rtgt);
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && (q.size() != 0 || flush_m); i++) begin
      if (flush_m || q.size() == 0) idle();
      else resolve(q[0].taken, q[0].taken ? q[0].tgt : 32'h0);
    end
  endtask

  initial begin
    logic [31:0] rpc, rtg, ptg;
    bit rpt, rrt, rpv, rrv;
    checks = 0; failures = 0; flush_m = 0;
    m_resolved = 0; m_mispred = 0; m_full = 0;
    rst = 1'b0;
    pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_hit = 0; pred_target = 0;
    res_valid = 0; res_taken = 0; res_target = 0;
    #2;
    chk("rst_count", count, 0);
    chk("rst_upd_valid", upd_valid, 0);
    chk("rst_redirect_valid", redirect_valid, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_upd_tag", upd_tag, 0);
    chk("rst_pred_ready", pred_ready, 1);
    @(posedge clk); #1;
    rst = 1'b1;

    // correct taken prediction
    push1(32'h100, 1, 1, 32'h200);
    resolve(1, 32'h200);

    // fill to full, reject 9th, one resolve reopens
    for (int i = 0; i < DEPTH; i++) push1(32'h1000 + 32'(i) * 4, 0, 0, 32'h1004 + 32'(i) * 4);
    push1(32'h2000, 0, 0, 32'h2004);
    resolve(0, 0);
    idle();
    drain();

    // mispredict with younger entries flushed
    push1(32'h40, 0, 0, 32'h44);
    for (int i = 0; i < 3; i++) push1(32'h3000 + 32'(i) * 4, 0, 0, 32'h3004 + 32'(i) * 4);
    resolve(1, 32'h80);
    push1(32'h500, 0, 0, 32'h504);
    push1(32'h500, 0, 0, 32'h504);
    drain();

    // redirect_pc wraparound
    push1(32'hFFFF_FFFC, 1, 1, 32'h10);
    resolve(0, 32'h0);
    idle();

    // resolve while empty, then push+resolve at count 3
    resolve(1, 32'h1234);
    for (int i = 0; i < 3; i++) push1(32'h600 + 32'(i) * 4, 0, 0, 32'h604 + 32'(i) * 4);
    step(1, 32'h700, 0, 0, 32'h704, 1, 0, 0);
    drain();

    // randomized traffic with mostly-correct predictions
    for (int c = 0; c < 1500; c++) begin
      rpv = $urandom_range(0, 9) < 7;
      rpc = $urandom & 32'hFFFF_FFFC;
      rpt = 1'($urandom);
      if (rpt) ptg = ($urandom_range(0, 3) == 0) ? $urandom : rpc + 32'h100;
      else     ptg = ($urandom_range(0, 7) == 0) ? $urandom : rpc + 32'd4;
      rrv = (c < 750) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 9) < 6);
      rrt = 1'($urandom);
      rtg = $urandom;
      if (q.size() != 0) begin
        rrt = ($urandom_range(0, 3) == 0) ? !q[0].taken : q[0].taken;
        if (rrt && $urandom_range(0, 3) != 0) rtg = q[0].tgt;
      end
      step(rpv, rpc, rpt, 1'($urandom), ptg, rrv, rrt, rtg);
    end
    drain();

    // asynchronous reset with 5 entries in flight
    for (int i = 0; i < 5; i++) push1(32'h800 + 32'(i) * 4, 0, 0, 32'h804 + 32'(i) * 4);
    chk("pre_rst_count", count, 5);
    rst = 1'b0;
    #1;
    chk("arst_count", count, 0);
    chk("arst_upd_valid", upd_valid, 0);
    chk("arst_redirect_valid", redirect_valid, 0);
    chk("arst_upd_target", upd_target, 0);
    q.delete(); flush_m = 0;
    m_resolved = 0; m_mispred = 0; m_full = 0;
    @(posedge clk); #1;
    rst = 1'b1;

    // one correct and one mispredicted resolve
    push1(32'h300, 0, 0, 32'h304);
    push1(32'h400, 1, 1, 32'h500);
    resolve(0, 0);
    resolve(0, 0);
    idle();
`ifdef BPU_STATS_EN
    chk("stat_resolved", stat_resolved, m_resolved);
    chk("stat_mispred", stat_mispred, m_mispred);
    chk("stat_full_cyc", stat_full_cyc, m_full);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
